// File: rtl/tx_huge_pages_regs_pkg.sv
// tx_hp_pkg: shared definitions for the huge-page BAR register receiver.
//   - TLP fmt/type codes for the accepted memory writes
//   - byte offsets of the register map inside the BAR
//   - byte-swap helper for payload dwords
//   - receive state enum and register-select record
package tx_hp_pkg;

  localparam logic [6:0]  FT_MWR32    = 7'b10_00000;
  localparam logic [6:0]  FT_MWR64    = 7'b11_00000;

  localparam logic [15:0] ADDR_BASE   = 16'h000;
  localparam logic [15:0] QW_BASE     = 16'h100;
  localparam logic [15:0] CMPL_LO     = 16'h180;
  localparam logic [15:0] CMPL_HI     = 16'h184;

  // trn_rrem_n value meaning only [63:32] carries data on the EOF beat
  localparam logic [7:0]  REM_HI_ONLY = 8'h0F;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR3,
    ST_HDR4,
    ST_DATA,
    ST_DROP
  } state_t;

  typedef enum logic [1:0] {
    RK_NONE,
    RK_ADDR,
    RK_QW,
    RK_CMPL
  } reg_kind_t;

  typedef struct packed {
    reg_kind_t   kind;
    logic [4:0]  idx;   // page number for RK_ADDR / RK_QW
    logic        hi;    // upper dword of a 64-bit register
  } reg_sel_t;

  // TLP payload arrives big-endian per dword; registers hold little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] dw);
    return {dw[7:0], dw[15:8], dw[23:16], dw[31:24]};
  endfunction

endpackage

// File: rtl/hp_status_ctl.sv
// hp_status_ctl: one huge-page status flop.
//   i_clk    clock
//   i_reset  synchronous active-high reset (status -> 0)
//   i_set    unlock commit, sets status (wins over clear)
//   i_clr    page-consumed pulse from the DMA engine, clears status
//   o_status 1 while the page is owned by hardware
module hp_status_ctl (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_set,
  input  logic i_clr,
  output logic o_status
);

  logic r_status;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_status <= 1'b0;
    end else if (i_set) begin
      r_status <= 1'b1;
    end else if (i_clr) begin
      r_status <= 1'b0;
    end
  end

  assign o_status = r_status;

endmodule

// File: rtl/tx_huge_pages_regs.sv
// tx_huge_pages_regs: TRN RX memory-write receiver for the TX huge-page registers.
//   trn_clk / reset            clock, synchronous active-high reset
//   trn_rd, trn_rrem_n         64-bit RX data (DW0 in [63:32]) and remainder
//   trn_rsof_n .. trn_rsrc_dsc_n, trn_rbar_hit_n, trn_rdst_rdy_n   RX framing (active-low)
//   huge_page_addr/qwords      per-page address and qword count, written by MWr
//   huge_page_status           per-page ownership, set on committed unlock
//   huge_page_free             per-page consumed pulse, clears status
//   completed_buffer_address   completion buffer address
// Register and completion dwords land as soon as their beat is accepted; unlocks
// (qword writes) are collected and only committed on a clean accepted EOF.
module tx_huge_pages_regs
  import tx_hp_pkg::*;
#(
  parameter int NUM_PAGES = 2,
  parameter int BAR_IDX   = 2,
  parameter int REG_AW    = 9
) (
  input  logic                      trn_clk,
  input  logic                      reset,
  input  logic [63:0]               trn_rd,
  input  logic [7:0]                trn_rrem_n,
  input  logic                      trn_rsof_n,
  input  logic                      trn_reof_n,
  input  logic                      trn_rsrc_rdy_n,
  input  logic                      trn_rsrc_dsc_n,
  input  logic [6:0]                trn_rbar_hit_n,
  input  logic                      trn_rdst_rdy_n,
  output logic [64*NUM_PAGES-1:0]   huge_page_addr,
  output logic [32*NUM_PAGES-1:0]   huge_page_qwords,
  output logic [NUM_PAGES-1:0]      huge_page_status,
  input  logic [NUM_PAGES-1:0]      huge_page_free,
  output logic [63:0]               completed_buffer_address
);

  state_t               r_state;
  logic [10:0]          r_rem;       // payload dwords still to be written
  logic [REG_AW-1:0]    r_off;       // byte offset of the next upper-lane dword
  logic [NUM_PAGES-1:0] r_pend;      // unlocks waiting for a clean EOF
  logic [63:0]          r_cmpl;

  logic                 w_acc, w_sof_hit, w_eof, w_dsc, w_lo_masked;
  logic [10:0]          w_len;
  logic [1:0]           w_we;
  logic [REG_AW-1:0]    w_off  [2];
  logic [31:0]          w_data [2];
  reg_sel_t             w_sel  [2];
  logic [NUM_PAGES-1:0] w_pend_set, w_unlock;
  logic                 w_unused;

  function automatic reg_sel_t decode_off(input logic [REG_AW-1:0] off);
    reg_sel_t s;
    int       o;
    o = int'(off);
    s = '{kind: RK_NONE, idx: 5'd0, hi: 1'b0};
    if (o >= int'(ADDR_BASE) && o < int'(QW_BASE)) begin
      if (((o - int'(ADDR_BASE)) >> 3) < NUM_PAGES) begin
        s.kind = RK_ADDR;
        s.idx  = 5'((o - int'(ADDR_BASE)) >> 3);
        s.hi   = o[2];
      end
    end else if (o >= int'(QW_BASE) && o < int'(CMPL_LO)) begin
      if (((o - int'(QW_BASE)) >> 2) < NUM_PAGES) begin
        s.kind = RK_QW;
        s.idx  = 5'((o - int'(QW_BASE)) >> 2);
      end
    end else if (o == int'(CMPL_LO)) begin
      s.kind = RK_CMPL;
    end else if (o == int'(CMPL_HI)) begin
      s.kind = RK_CMPL;
      s.hi   = 1'b1;
    end
    return s;
  endfunction

  assign w_acc       = !trn_rsrc_rdy_n && !trn_rdst_rdy_n;
  assign w_sof_hit   = !trn_rsof_n && !trn_rbar_hit_n[BAR_IDX];
  assign w_eof       = !trn_reof_n;
  assign w_dsc       = !trn_rsrc_dsc_n;
  assign w_lo_masked = w_eof && (trn_rrem_n == REM_HI_ONLY);
  assign w_len       = (trn_rd[41:32] == 10'd0) ? 11'd1024 : {1'b0, trn_rd[41:32]};
  assign w_unused    = ^trn_rbar_hit_n;

  // Two write lanes: lane 0 = upper dword (or the single HDR3 dword), lane 1 = lower.
  always_comb begin
    w_we       = '0;
    w_off[0]   = r_off;
    w_off[1]   = r_off + REG_AW'(4);
    w_data[0]  = bswap32(trn_rd[63:32]);
    w_data[1]  = bswap32(trn_rd[31:0]);
    w_pend_set = '0;
    case (r_state)
      ST_HDR3: begin
        // DW2 low two bits are reserved, keep the offset dword aligned
        w_off[0]  = {trn_rd[REG_AW+31:34], 2'b00};
        w_data[0] = bswap32(trn_rd[31:0]);
        w_we[0]   = w_acc && !w_lo_masked;
      end
      ST_DATA: begin
        w_we[0] = w_acc && (r_rem >= 11'd1);
        w_we[1] = w_acc && (r_rem >= 11'd2) && !w_lo_masked;
      end
      default: ;
    endcase
    for (int l = 0; l < 2; l++) begin
      w_sel[l] = decode_off(w_off[l]);
      for (int p = 0; p < NUM_PAGES; p++) begin
        if (w_we[l] && w_sel[l].kind == RK_QW && w_sel[l].idx == 5'(p)) begin
          w_pend_set[p] = 1'b1;
        end
      end
    end
    // A qword written on the EOF beat itself still counts toward this commit.
    w_unlock = (w_acc && w_eof && !w_dsc) ? (r_pend | w_pend_set) : '0;
  end

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_rem   <= '0;
      r_off   <= '0;
      r_pend  <= '0;
      r_cmpl  <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (w_we[l] && w_sel[l].kind == RK_CMPL) begin
          if (w_sel[l].hi) r_cmpl[63:32] <= w_data[l];
          else             r_cmpl[31:0]  <= w_data[l];
        end
      end
      if (w_acc) begin
        r_pend <= (w_eof || w_dsc) ? '0 : (r_pend | w_pend_set);
        if (w_dsc) begin
          r_state <= ST_IDLE;
        end else begin
          case (r_state)
            ST_IDLE: begin
              if (w_sof_hit && !w_eof) begin
                r_rem <= w_len;
                if (trn_rd[46])                      r_state <= ST_DROP;
                else if (trn_rd[62:56] == FT_MWR32)  r_state <= ST_HDR3;
                else if (trn_rd[62:56] == FT_MWR64)  r_state <= ST_HDR4;
                else                                 r_state <= ST_DROP;
              end
            end
            ST_HDR3: begin
              r_off   <= w_off[0] + REG_AW'(4);
              r_rem   <= r_rem - 11'd1;
              r_state <= w_eof ? ST_IDLE : ST_DATA;
            end
            ST_HDR4: begin
              r_off   <= {trn_rd[REG_AW-1:2], 2'b00};
              r_state <= w_eof ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
              r_off <= r_off + REG_AW'(8);
              r_rem <= r_rem - {10'd0, w_we[0]} - {10'd0, w_we[1]};
              if (w_eof) r_state <= ST_IDLE;
            end
            ST_DROP: begin
              if (w_eof) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign completed_buffer_address = r_cmpl;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PAGES; gi++) begin : g_page
      logic [63:0] r_addr;
      logic [31:0] r_qw;

      always_ff @(posedge trn_clk) begin
        if (reset) begin
          r_addr <= '0;
          r_qw   <= '0;
        end else begin
          for (int l = 0; l < 2; l++) begin
            if (w_we[l] && w_sel[l].idx == 5'(gi)) begin
              if (w_sel[l].kind == RK_ADDR) begin
                if (w_sel[l].hi) r_addr[63:32] <= w_data[l];
                else             r_addr[31:0]  <= w_data[l];
              end else if (w_sel[l].kind == RK_QW) begin
                r_qw <= w_data[l];
              end
            end
          end
        end
      end

      assign huge_page_addr[64*gi +: 64]   = r_addr;
      assign huge_page_qwords[32*gi +: 32] = r_qw;

      hp_status_ctl u_status (
        .i_clk    (trn_clk),
        .i_reset  (reset),
        .i_set    (w_unlock[gi]),
        .i_clr    (huge_page_free[gi]),
        .o_status (huge_page_status[gi])
      );
    end
  endgenerate

endmodule
